// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stage registers: register encodings,
// control field widths and the packed per-stage control word.
package pipeline_pkg;

    localparam int REG_W    = 4;
    localparam int OPTYPE_W = 2;
    localparam int OPCODE_W = 4;

    // Rd value that can never match a real source register, so bubbles never forward.
    localparam logic [REG_W-1:0] NO_REG = 4'hF;

    typedef struct packed {
        logic [REG_W-1:0]    Rd;
        logic [OPTYPE_W-1:0] opType;
        logic [OPCODE_W-1:0] opCode;
        logic                regWrite;
        logic                valid;
    } stage_ctrl_t;

    localparam stage_ctrl_t BUBBLE_CTRL = '{NO_REG, 2'b00, 4'b0000, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: async reset and synchronous clear both load RST_VAL,
// clear beats enable so a flush always wins over a hold.
module pipe_stage_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else if (clr) begin
            data_q <= RST_VAL;
        end else if (en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// IF/ID, ID/EX, EX/MEM and MEM/WB registers with stall, per-stage flush and an
// optional bubble counter enabled by macro PIPE_PERF_CNT_EN.
module pipeline_stage_regs
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush1,
    input  logic                flush2,
    input  logic                flush3,
    input  logic                flush4,
    input  logic                flush5,
    input  logic [DATA_W-1:0]   if_instr,
    input  logic [DATA_W-1:0]   if_pc,
    input  logic [REG_W-1:0]    id_Rd,
    input  logic [OPTYPE_W-1:0] id_opType,
    input  logic [OPCODE_W-1:0] id_opCode,
    input  logic                id_regWrite,
    input  logic [DATA_W-1:0]   ex_aluResult,
    input  logic [DATA_W-1:0]   mem_Result,
    output logic [DATA_W-1:0]   ifid_instr,
    output logic [DATA_W-1:0]   ifid_pc,
    output logic                ifid_valid,
    output logic [REG_W-1:0]    idex_Rd,
    output logic [OPTYPE_W-1:0] idex_opType,
    output logic [OPCODE_W-1:0] idex_opCode,
    output logic                idex_regWrite,
    output logic                idex_valid,
    output logic [REG_W-1:0]    Rd_EXMEM,
    output logic [OPTYPE_W-1:0] exmem_opType,
    output logic [DATA_W-1:0]   exmem_aluResult,
    output logic                exmem_valid,
    output logic [REG_W-1:0]    Rd_MEMWB,
    output logic [DATA_W-1:0]   memwb_Result,
    output logic                memwb_regWrite,
    output logic                memwb_valid,
    output logic [15:0]         bubble_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic              valid;
    } ifid_t;

    typedef struct packed {
        logic [REG_W-1:0]    Rd;
        logic [OPTYPE_W-1:0] opType;
        logic                regWrite;
        logic                valid;
        logic [DATA_W-1:0]   aluResult;
    } exmem_t;

    typedef struct packed {
        logic [REG_W-1:0]  Rd;
        logic              regWrite;
        logic              valid;
        logic [DATA_W-1:0] result;
    } memwb_t;

    localparam ifid_t  IFID_BUBBLE  = ifid_t'('0);
    localparam exmem_t EXMEM_BUBBLE = exmem_t'({NO_REG, {(DATA_W + 4){1'b0}}});
    localparam memwb_t MEMWB_BUBBLE = memwb_t'({NO_REG, {(DATA_W + 2){1'b0}}});

    logic        fValid_q;
    ifid_t       ifid_d, ifid_q;
    stage_ctrl_t idex_d, idex_q;
    exmem_t      exmem_d, exmem_q;
    memwb_t      memwb_d, memwb_q;

    // The fetch token becomes valid on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fValid_q <= 1'b0;
        end else begin
            fValid_q <= 1'b1;
        end
    end

    assign ifid_d  = '{if_instr, if_pc, fValid_q & ~flush1};
    assign idex_d  = '{id_Rd, id_opType, id_opCode, id_regWrite, 1'b1};
    assign exmem_d = '{idex_q.Rd, idex_q.opType, idex_q.regWrite, 1'b1, ex_aluResult};
    assign memwb_d = '{exmem_q.Rd, exmem_q.regWrite, 1'b1, mem_Result};

    pipe_stage_reg #(.W($bits(ifid_t)), .RST_VAL(IFID_BUBBLE)) u_ifid (
        .clk(clk), .rst(rst), .en(~stall), .clr(flush2), .d(ifid_d), .q(ifid_q)
    );

    // Invalid upstream entries are loaded as full bubbles so valid gates every field.
    pipe_stage_reg #(.W($bits(stage_ctrl_t)), .RST_VAL(BUBBLE_CTRL)) u_idex (
        .clk(clk), .rst(rst), .en(1'b1), .clr(flush3 | stall | ~ifid_q.valid),
        .d(idex_d), .q(idex_q)
    );

    pipe_stage_reg #(.W($bits(exmem_t)), .RST_VAL(EXMEM_BUBBLE)) u_exmem (
        .clk(clk), .rst(rst), .en(1'b1), .clr(flush4 | ~idex_q.valid),
        .d(exmem_d), .q(exmem_q)
    );

    pipe_stage_reg #(.W($bits(memwb_t)), .RST_VAL(MEMWB_BUBBLE)) u_memwb (
        .clk(clk), .rst(rst), .en(1'b1), .clr(flush5 | ~exmem_q.valid),
        .d(memwb_d), .q(memwb_q)
    );

    assign ifid_instr      = ifid_q.instr;
    assign ifid_pc         = ifid_q.pc;
    assign ifid_valid      = ifid_q.valid;
    assign idex_Rd         = idex_q.Rd;
    assign idex_opType     = idex_q.opType;
    assign idex_opCode     = idex_q.opCode;
    assign idex_regWrite   = idex_q.regWrite;
    assign idex_valid      = idex_q.valid;
    assign Rd_EXMEM        = exmem_q.valid ? exmem_q.Rd : NO_REG;
    assign exmem_opType    = exmem_q.opType;
    assign exmem_aluResult = exmem_q.aluResult;
    assign exmem_valid     = exmem_q.valid;
    assign Rd_MEMWB        = memwb_q.valid ? memwb_q.Rd : NO_REG;
    assign memwb_Result    = memwb_q.result;
    assign memwb_regWrite  = memwb_q.regWrite;
    assign memwb_valid     = memwb_q.valid;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] bubbleCnt_d, bubbleCnt_q;

    // Counts only stall/flush3 bubbles, not those caused by an empty IF/ID.
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        if ((stall || flush3) && (bubbleCnt_q != 16'hFFFF)) begin
            bubbleCnt_d = bubbleCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubbleCnt_q <= 16'h0000;
        end else begin
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign bubble_cnt = bubbleCnt_q;
`else
    assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed self-checking bench for pipeline_stage_regs; bubble_cnt expectations
// follow whether PIPE_PERF_CNT_EN is defined for the build.
module tb_pipeline_stage_regs;

`ifdef PIPE_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush1, flush2, flush3, flush4, flush5;
    logic [31:0] if_instr, if_pc;
    logic [3:0]  id_Rd;
    logic [1:0]  id_opType;
    logic [3:0]  id_opCode;
    logic        id_regWrite;
    logic [31:0] ex_aluResult, mem_Result;
    logic [31:0] ifid_instr, ifid_pc;
    logic        ifid_valid;
    logic [3:0]  idex_Rd;
    logic [1:0]  idex_opType;
    logic [3:0]  idex_opCode;
    logic        idex_regWrite, idex_valid;
    logic [3:0]  Rd_EXMEM;
    logic [1:0]  exmem_opType;
    logic [31:0] exmem_aluResult;
    logic        exmem_valid;
    logic [3:0]  Rd_MEMWB;
    logic [31:0] memwb_Result;
    logic        memwb_regWrite, memwb_valid;
    logic [15:0] bubble_cnt;

    int          testCount = 0;
    int          failCount = 0;
    logic [15:0] expCnt    = 16'h0000;

    always #5 clk = ~clk;

    pipeline_stage_regs #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .flush1(flush1), .flush2(flush2), .flush3(flush3), .flush4(flush4), .flush5(flush5),
        .if_instr(if_instr), .if_pc(if_pc),
        .id_Rd(id_Rd), .id_opType(id_opType), .id_opCode(id_opCode), .id_regWrite(id_regWrite),
        .ex_aluResult(ex_aluResult), .mem_Result(mem_Result),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .idex_Rd(idex_Rd), .idex_opType(idex_opType), .idex_opCode(idex_opCode),
        .idex_regWrite(idex_regWrite), .idex_valid(idex_valid),
        .Rd_EXMEM(Rd_EXMEM), .exmem_opType(exmem_opType), .exmem_aluResult(exmem_aluResult),
        .exmem_valid(exmem_valid),
        .Rd_MEMWB(Rd_MEMWB), .memwb_Result(memwb_Result), .memwb_regWrite(memwb_regWrite),
        .memwb_valid(memwb_valid),
        .bubble_cnt(bubble_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs (flush bits are {flush5..flush1}) and samples 1 ns after the edge.
    task automatic applyStimulus(input logic [3:0] rd, input logic [31:0] instr,
                                 input logic stl, input logic [4:0] fl);
        if_instr     = instr;
        if_pc        = {26'h0, rd, 2'b00};
        id_Rd        = rd;
        id_opType    = rd[1:0];
        id_opCode    = rd;
        id_regWrite  = 1'b1;
        ex_aluResult = 32'hA000_0000 | {28'h0, rd};
        mem_Result   = 32'hB000_0000 | {28'h0, rd};
        stall        = stl;
        {flush5, flush4, flush3, flush2, flush1} = fl;
        if (CNT_EN && (stl || fl[2])) expCnt = expCnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        {flush5, flush4, flush3, flush2, flush1} = 5'b0;
        if_instr = '0; if_pc = '0; id_Rd = '0; id_opType = '0; id_opCode = '0;
        id_regWrite = 1'b0; ex_aluResult = '0; mem_Result = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ifid_valid", ifid_valid, 1'b0);
        checkOutput("rst_idex_Rd", idex_Rd, 4'hF);
        checkOutput("rst_Rd_EXMEM", Rd_EXMEM, 4'hF);
        checkOutput("rst_Rd_MEMWB", Rd_MEMWB, 4'hF);
        checkOutput("rst_memwb_valid", memwb_valid, 1'b0);
        checkOutput("rst_bubble_cnt", bubble_cnt, 16'h0);
        rst = 1'b0;

        applyStimulus(4'd0, 32'h0, 1'b0, 5'b0);
        checkOutput("first_edge_ifid_valid", ifid_valid, 1'b0);
        applyStimulus(4'd0, 32'h0, 1'b0, 5'b0);
        checkOutput("second_edge_ifid_valid", ifid_valid, 1'b1);

        // Back-to-back instructions Rd=1..4 flow with no gaps.
        applyStimulus(4'd1, 32'h1, 1'b0, 5'b0);
        checkOutput("seq_idex_Rd1", idex_Rd, 4'd1);
        checkOutput("seq_idex_valid", idex_valid, 1'b1);
        applyStimulus(4'd2, 32'h2, 1'b0, 5'b0);
        checkOutput("seq_Rd_EXMEM1", Rd_EXMEM, 4'd1);
        checkOutput("seq_idex_Rd2", idex_Rd, 4'd2);
        checkOutput("seq_exmem_alu", exmem_aluResult, 32'hA000_0002);
        checkOutput("seq_exmem_opType", exmem_opType, 2'd1);
        applyStimulus(4'd3, 32'h3, 1'b0, 5'b0);
        checkOutput("seq_Rd_MEMWB1", Rd_MEMWB, 4'd1);
        checkOutput("seq_Rd_EXMEM2", Rd_EXMEM, 4'd2);
        checkOutput("seq_memwb_result", memwb_Result, 32'hB000_0003);
        checkOutput("seq_memwb_regWrite", memwb_regWrite, 1'b1);
        applyStimulus(4'd4, 32'hE081_1002, 1'b0, 5'b0);
        checkOutput("seq_Rd_MEMWB2", Rd_MEMWB, 4'd2);
        checkOutput("seq_Rd_EXMEM3", Rd_EXMEM, 4'd3);
        checkOutput("seq_ifid_instr", ifid_instr, 32'hE081_1002);

        // One-cycle stall holds IF/ID and bubbles ID/EX.
        applyStimulus(4'd5, 32'h1111_1111, 1'b1, 5'b0);
        checkOutput("stall_ifid_hold", ifid_instr, 32'hE081_1002);
        checkOutput("stall_idex_valid", idex_valid, 1'b0);
        checkOutput("stall_idex_Rd", idex_Rd, 4'hF);
        checkOutput("stall_idex_regWrite", idex_regWrite, 1'b0);
        checkOutput("stall_Rd_EXMEM", Rd_EXMEM, 4'd4);
        checkOutput("stall_Rd_MEMWB", Rd_MEMWB, 4'd3);
        checkOutput("stall_bubble_cnt", bubble_cnt, expCnt);
        applyStimulus(4'd6, 32'h2222_2222, 1'b0, 5'b0);
        checkOutput("post_stall_ifid", ifid_instr, 32'h2222_2222);
        checkOutput("post_stall_idex_Rd", idex_Rd, 4'd6);
        checkOutput("bubble_exmem_valid", exmem_valid, 1'b0);
        checkOutput("bubble_Rd_EXMEM", Rd_EXMEM, 4'hF);
        checkOutput("bubble_exmem_alu", exmem_aluResult, 32'h0);
        checkOutput("post_stall_Rd_MEMWB", Rd_MEMWB, 4'd4);
        applyStimulus(4'd7, 32'h3333_3333, 1'b0, 5'b0);
        checkOutput("bubble_memwb_valid", memwb_valid, 1'b0);
        checkOutput("bubble_memwb_regWrite", memwb_regWrite, 1'b0);
        checkOutput("bubble_Rd_MEMWB", Rd_MEMWB, 4'hF);
        applyStimulus(4'd8, 32'h3333_3334, 1'b0, 5'b0);
        checkOutput("refill_Rd_EXMEM", Rd_EXMEM, 4'd7);

        // Branch taken: flush IF/ID, ID/EX and EX/MEM while MEM/WB advances.
        applyStimulus(4'd9, 32'h3333_3335, 1'b0, 5'b01110);
        checkOutput("br_ifid_valid", ifid_valid, 1'b0);
        checkOutput("br_idex_valid", idex_valid, 1'b0);
        checkOutput("br_exmem_valid", exmem_valid, 1'b0);
        checkOutput("br_Rd_EXMEM", Rd_EXMEM, 4'hF);
        checkOutput("br_Rd_MEMWB", Rd_MEMWB, 4'd7);
        checkOutput("br_memwb_valid", memwb_valid, 1'b1);
        checkOutput("br_bubble_cnt", bubble_cnt, expCnt);

        // Stall and flush2 together: flush wins on IF/ID.
        applyStimulus(4'd10, 32'h4444_4444, 1'b1, 5'b00010);
        checkOutput("sf_ifid_valid", ifid_valid, 1'b0);
        checkOutput("sf_ifid_instr", ifid_instr, 32'h0);
        checkOutput("sf_idex_valid", idex_valid, 1'b0);
        checkOutput("sf_bubble_cnt", bubble_cnt, expCnt);
        applyStimulus(4'd11, 32'h5555_5555, 1'b0, 5'b0);
        checkOutput("sf_refill_ifid", ifid_instr, 32'h5555_5555);
        checkOutput("sf_empty_idex_cnt", bubble_cnt, expCnt);

        applyStimulus(4'd12, 32'h6666_6666, 1'b0, 5'b00001);
        checkOutput("f1_ifid_valid", ifid_valid, 1'b0);
        checkOutput("f1_idex_Rd", idex_Rd, 4'd12);
        applyStimulus(4'd13, 32'h7777_7777, 1'b0, 5'b10000);
        checkOutput("f5_memwb_valid", memwb_valid, 1'b0);
        checkOutput("f5_Rd_MEMWB", Rd_MEMWB, 4'hF);
        checkOutput("f5_Rd_EXMEM", Rd_EXMEM, 4'd12);
        checkOutput("f5_idex_valid", idex_valid, 1'b0);

        // Reset pulse between edges clears everything before the next edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ifid_valid", ifid_valid, 1'b0);
        checkOutput("mid_rst_idex_Rd", idex_Rd, 4'hF);
        checkOutput("mid_rst_Rd_EXMEM", Rd_EXMEM, 4'hF);
        checkOutput("mid_rst_exmem_alu", exmem_aluResult, 32'h0);
        checkOutput("mid_rst_memwb_result", memwb_Result, 32'h0);
        checkOutput("mid_rst_bubble_cnt", bubble_cnt, 16'h0);
        rst = 1'b0;
        expCnt = 16'h0000;
        applyStimulus(4'd1, 32'h8888_8888, 1'b0, 5'b0);
        checkOutput("rel1_ifid_valid", ifid_valid, 1'b0);
        applyStimulus(4'd2, 32'h9999_9999, 1'b0, 5'b0);
        checkOutput("rel2_ifid_valid", ifid_valid, 1'b1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'd3, 32'hAAAA_0000 | i, 1'b1, 5'b0);
            applyStimulus(4'd4, 32'hBBBB_0000 | i, 1'b0, 5'b0);
        end
        checkOutput("toggle_bubble_cnt", bubble_cnt, expCnt);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
